// File: rtl/reg_status_file_pkg.sv
// Shared constants for the register status file, dispatcher and reorder buffer.
package reg_status_file_pkg;

    localparam int REG_COUNT = 32;
    localparam int REG_W     = 5;
    localparam int DATA_W    = 32;
    localparam int ROB_SIZE  = 16;
    localparam int TAG_W     = $clog2(ROB_SIZE) + 1;

    // One past the last ROB entry: "not renamed, value is valid".
    localparam logic [TAG_W-1:0] NO_TAG = TAG_W'(ROB_SIZE);

endpackage

// File: rtl/reg_read_port.sv
// One source-operand lookup: x0 check, tag/value select and commit bypass.
module reg_read_port
    import reg_status_file_pkg::*;
(
    input  logic [REG_W-1:0]                  rs,
    input  logic [REG_COUNT-1:0][TAG_W-1:0]   tags,
    input  logic [REG_COUNT-1:0][DATA_W-1:0]  values,
    input  logic                              commit_en,
    input  logic [REG_W-1:0]                  commit_rd,
    input  logic [TAG_W-1:0]                  commit_tag,
    input  logic [DATA_W-1:0]                 commit_value,
    output logic [TAG_W-1:0]                  q,
    output logic [DATA_W-1:0]                 v
);

    // Select stored tag/value, forwarding a retiring result whose tag still owns the register.
    always_comb begin
        q = NO_TAG;
        v = '0;
        if (rs != '0) begin
            if (commit_en && (commit_rd == rs) && (tags[rs] == commit_tag)) begin
                q = NO_TAG;
                v = commit_value;
            end else begin
                q = tags[rs];
                v = values[rs];
            end
        end
    end

endmodule

// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename tags; the commit end of the ROB.
module reg_status_file
    import reg_status_file_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               flush,
    input  logic               rename_en,
    input  logic [REG_W-1:0]   rename_rd,
    input  logic [TAG_W-1:0]   rename_tag,
    input  logic [REG_W-1:0]   rs1,
    input  logic [REG_W-1:0]   rs2,
    output logic [TAG_W-1:0]   qj,
    output logic [TAG_W-1:0]   qk,
    output logic [DATA_W-1:0]  vj,
    output logic [DATA_W-1:0]  vk,
    input  logic               commit_en,
    input  logic [REG_W-1:0]   commit_rd,
    input  logic [DATA_W-1:0]  commit_value,
    input  logic [TAG_W-1:0]   commit_tag
);

    logic [REG_COUNT-1:0][DATA_W-1:0] value_q;
    logic [REG_COUNT-1:0][TAG_W-1:0]  tag_q;

    logic do_rename;
    logic do_commit;

    assign do_rename = rdy && rename_en && !flush && (rename_rd != '0);
    assign do_commit = rdy && commit_en && (commit_rd != '0);

    // Values change only on commit; in-order retirement makes the write always correct.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else if (do_commit) begin
            value_q[commit_rd] <= commit_value;
        end
    end

    // Tag update per register: flush > rename > commit clear (only if the retiring tag still owns it).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                tag_q[i] <= NO_TAG;
            end
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (flush) begin
                    tag_q[i] <= NO_TAG;
                end else if (do_rename && (rename_rd == REG_W'(i))) begin
                    tag_q[i] <= rename_tag;
                end else if (do_commit && (commit_rd == REG_W'(i)) && (tag_q[i] == commit_tag)) begin
                    tag_q[i] <= NO_TAG;
                end
            end
        end
    end

    reg_read_port u_port_j (
        .rs           (rs1),
        .tags         (tag_q),
        .values       (value_q),
        .commit_en    (commit_en),
        .commit_rd    (commit_rd),
        .commit_tag   (commit_tag),
        .commit_value (commit_value),
        .q            (qj),
        .v            (vj)
    );

    reg_read_port u_port_k (
        .rs           (rs2),
        .tags         (tag_q),
        .values       (value_q),
        .commit_en    (commit_en),
        .commit_rd    (commit_rd),
        .commit_tag   (commit_tag),
        .commit_value (commit_value),
        .q            (qk),
        .v            (vk)
    );

endmodule

// File: doc/reg_status_file.md
# reg_status_file

Architectural register file with rename status, the receiving end of the reorder buffer's commit interface. Holds 32 × 32-bit integer registers plus a per-register rename tag (producing ROB entry or NO_TAG). The dispatcher renames destinations into it and reads source operands/tags from it; the reorder buffer retires results into it. It sits between the dispatcher and the reorder buffer. A mispredict flush drops all pending renames.

## Interface
- REG_COUNT, 32: architectural registers; x0 hard-wired to zero.
- REG_W, 5: register index width.
- DATA_W, 32: register value width.
- TAG_W, 5: rename tag width; ROB entries 0..15.
- NO_TAG, 16: tag value meaning "not renamed / value valid".

- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- rdy  in  1  global ready; low freezes rename and commit updates.
- flush  in  1  mispredict; clear all rename tags.
- rename_en  in  1  dispatcher renames rename_rd this cycle.
- rename_rd  in  REG_W  destination register being renamed.
- rename_tag  in  TAG_W  ROB entry allocated for that destination.
- rs1, rs2  in  REG_W  source register indices from the dispatcher.
- qj, qk  out  TAG_W  source tags; NO_TAG when the value is valid.
- vj, vk  out  DATA_W  source values; meaningful only when the tag is NO_TAG.
- commit_en  in  1  reorder buffer retires a register-writing instruction.
- commit_rd  in  REG_W  destination of the retiring instruction.
- commit_value  in  DATA_W  result.
- commit_tag  in  TAG_W  ROB entry being retired.

## Operation
- State: value[0..31] and tag[0..31].
- Lookup is combinational per source and reflects state before this cycle's rename. An instruction's own rd rename never affects its own sources.
- Lookup bypass: if commit_en, commit_rd == rsX, rsX != 0, and tag[rsX] == commit_tag, then output qX = NO_TAG and vX = commit_value. Otherwise output qX = tag[rsX] and vX = value[rsX].
- rsX == 0 always returns qX = NO_TAG and vX = 0.
- Commit, when rdy and commit_rd != 0:
  - value[commit_rd] <= commit_value unconditionally. The in-order commit means this write is always architecturally correct.
  - tag[commit_rd] <= NO_TAG only if tag[commit_rd] == commit_tag and the same register is not being renamed this cycle.
  - A tag mismatch means a younger rename is outstanding; keep the tag.
- Rename, when rdy, rename_en, no flush, and rename_rd != 0: tag[rename_rd] <= rename_tag. Rename has priority over the commit tag clear on the same register.
- Flush, regardless of rdy:
  - All tags go to NO_TAG.
  - Values are retained.
  - A same-cycle commit value write still lands if rdy is high.
  - A same-cycle rename is discarded.
- Reset, regardless of rdy: all values 0, all tags NO_TAG. Rename and commit are ignored that cycle.
- Writes to x0, by rename or commit, are dropped.

## Timing
- Lookup: zero-cycle combinational, including the same-cycle commit bypass.
- Rename and commit state updates become visible to lookup on the next cycle.
- Reset output values (rs = any): qj = qk = NO_TAG, vj = vk = 0.
- Priority per register per cycle: rst > flush (tags) > rename (tag) > commit clear (tag). The value is written only by commit, or cleared by rst.
- rdy low: no rename or commit updates; lookup remains combinational from held state.
- Simultaneous commit and rename of the same rd: value updated, tag = rename_tag.

## Structure
- Shared define header holds REG_W, DATA_W, TAG_W, NO_TAG and ROB size, the same constants the reorder buffer and dispatcher use.
- One sub-module, reg_read_port, instanced twice (rs1 and rs2). It contains the x0 check, tag/value select and commit bypass compare.

## Test plan
- Reset, then read rs1=5, rs2=0 -> qj=16, vj=0, qk=16, vk=0.
- Rename x5->tag 3. Next cycle read rs1=5 -> qj=3. Commit x5, tag 3, value 0xDEADBEEF -> same-cycle read qj=16, vj=0xDEADBEEF; next cycle tag[5]=16.
- Rename x7->2, then x7->9. Commit x7 tag 2 value 0x11 -> value[7]=0x11, qj stays 9. Commit tag 9 value 0x22 -> qj=16, vj=0x22.
- Same cycle: commit x4 tag 1 value 0x40 and rename x4->6. Next cycle qj=6; after commit of tag 6 value 0x44, vj=0x44.
- Rename x1->1, x2->2, then flush together with commit x3 tag 0 value 0x33 and rename x8->4 -> all tags 16, value[3]=0x33, x8 not renamed.
- Rename x0->5 and commit x0 value 0xFF -> read rs1=0 gives qj=16, vj=0. With rdy=0, rename x6->7 -> tag[6] unchanged.
